// File: rtl/bcd_pkg.sv
// Shared constants, converter state type and sizing helper for the BCD display slice.
package bcd_pkg;

   localparam int BCD_W = 4;
   localparam logic [BCD_W-1:0] ADD3_THRESHOLD = 4'd5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      COMMIT = 2'd2
   } conv_state_e;

   // Width of the digit_place index; never narrower than one bit.
   function automatic int bcd_place_w(input int digits);
      return (digits > 1) ? $clog2(digits) : 1;
   endfunction

endpackage

// File: rtl/double_dabble_core.sv
// Iterative binary-to-BCD converter: one double-dabble step per clock behind a valid/ready handshake.
// commit is high in the cycle whose closing edge publishes bcd/ovf; done pulses right after it.
module double_dabble_core
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_binary,
   output logic                      in_ready,
   output logic                      commit,
   output logic                      done,
   output logic [BCD_W*DIGITS-1:0]   bcd,
   output logic                      ovf
);

   localparam int SW = BCD_W * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

   conv_state_e       state_q;
   logic [WIDTH-1:0]  word_q;
   logic [WIDTH-1:0]  word_d;
   logic [SW-1:0]     scratch_q;
   logic [SW-1:0]     scratch_d;
   logic [SW-1:0]     adj;
   logic [CW-1:0]     cnt_q;
   logic              ovf_q;
   logic              carry_d;
   logic              ready_q;
   logic              done_q;

   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
      logic [BCD_W-1:0] nib;
      assign nib = scratch_q[gi*BCD_W +: BCD_W];
      assign adj[gi*BCD_W +: BCD_W] = (nib >= ADD3_THRESHOLD) ? nib + 4'd3 : nib;
   end

   // The bit leaving the top nibble means the value no longer fits in DIGITS digits.
   assign {carry_d, scratch_d, word_d} = {adj, word_q, 1'b0};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         word_q    <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (in_valid && ready_q) begin
                  word_q    <= in_binary;
                  scratch_q <= '0;
                  ovf_q     <= 1'b0;
                  cnt_q     <= CNT_LOAD;
                  ready_q   <= 1'b0;
                  state_q   <= SHIFT;
               end
            end
            SHIFT: begin
               word_q    <= word_d;
               scratch_q <= scratch_d;
               ovf_q     <= ovf_q | carry_d;
               cnt_q     <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               ready_q <= 1'b1;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: begin
               ready_q <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready = ready_q;
   assign commit   = (state_q == COMMIT);
   assign done     = done_q;
   assign bcd      = scratch_q;
   assign ovf      = ovf_q;

endmodule

// File: rtl/bcd_scan_display.sv
// Binary-to-BCD converter feeding a frame-synchronous multiplexed digit scanner.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero blanking on digit_blank).
module bcd_scan_display
   import bcd_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int DIGITS     = 5,
   parameter int DWELL_POW2 = 14
) (
   input  logic                              clock,
   input  logic                              reset_n,
   input  logic                              in_valid,
   input  logic [WIDTH-1:0]                  in_binary,
   output logic                              in_ready,
   output logic                              conv_done,
   output logic [3:0]                        digit,
   output logic [bcd_place_w(DIGITS)-1:0]    digit_place,
   output logic                              digit_blank,
   output logic                              overflow
);

   localparam int SW = BCD_W * DIGITS;
   localparam int PW = bcd_place_w(DIGITS);
   localparam logic [PW-1:0] LAST_PLACE = PW'(DIGITS - 1);

   logic                  core_commit;
   logic [SW-1:0]         core_bcd;
   logic                  core_ovf;
   logic [SW-1:0]         pending_q;
   logic                  pending_ovf_q;
   logic                  pending_valid_q;
   logic [SW-1:0]         display_q;
   logic                  display_ovf_q;
   logic [DWELL_POW2-1:0] dwell_q;
   logic [PW-1:0]         place_q;
   logic                  frame_start;

   double_dabble_core #(
      .WIDTH  (WIDTH),
      .DIGITS (DIGITS)
   ) u_core (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_binary (in_binary),
      .in_ready  (in_ready),
      .commit    (core_commit),
      .done      (conv_done),
      .bcd       (core_bcd),
      .ovf       (core_ovf)
   );

   // The edge that wraps place 0 back to the most significant digit starts a new frame.
   assign frame_start = (&dwell_q) && (place_q == '0);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dwell_q <= '0;
         place_q <= LAST_PLACE;
      end else begin
         dwell_q <= dwell_q + 1'b1;
         if (&dwell_q) begin
            place_q <= (place_q == '0) ? LAST_PLACE : place_q - 1'b1;
         end
      end
   end

   // A commit landing on the frame-start edge bypasses pending so it is shown without a frame of delay.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pending_q       <= '0;
         pending_ovf_q   <= 1'b0;
         pending_valid_q <= 1'b0;
         display_q       <= '0;
         display_ovf_q   <= 1'b0;
      end else if (frame_start) begin
         if (core_commit) begin
            display_q       <= core_bcd;
            display_ovf_q   <= core_ovf;
            pending_valid_q <= 1'b0;
         end else if (pending_valid_q) begin
            display_q       <= pending_q;
            display_ovf_q   <= pending_ovf_q;
            pending_valid_q <= 1'b0;
         end
      end else if (core_commit) begin
         pending_q       <= core_bcd;
         pending_ovf_q   <= core_ovf;
         pending_valid_q <= 1'b1;
      end
   end

   always_comb begin
      digit = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (place_q == PW'(i)) begin
            digit = display_q[i*BCD_W +: BCD_W];
         end
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic seen_nonzero;
   always_comb begin
      digit_blank  = 1'b0;
      seen_nonzero = 1'b0;
      for (int i = DIGITS - 1; i > 0; i--) begin
         seen_nonzero = seen_nonzero | (|display_q[i*BCD_W +: BCD_W]);
         if ((place_q == PW'(i)) && !seen_nonzero) begin
            digit_blank = 1'b1;
         end
      end
   end
`else
   assign digit_blank = 1'b0;
`endif

   assign digit_place = place_q;
   assign overflow    = display_ovf_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: two instances (5 and 3 digits, 4-clock dwell) with per-instance scoreboards.
`timescale 1ns/1ps
module tb_bcd_scan_display;

   localparam int DA  = 5;
   localparam int DB  = 3;
   localparam int LAT = 17;

   logic        clock   = 1'b0;
   logic        reset_n = 1'b0;

   logic        a_in_valid  = 1'b0;
   logic [15:0] a_in_binary = '0;
   logic        a_in_ready, a_conv_done, a_blank, a_ovf;
   logic [3:0]  a_digit;
   logic [2:0]  a_place;
   logic [2:0]  a_place_before = 3'd4;

   logic        b_in_valid  = 1'b0;
   logic [15:0] b_in_binary = '0;
   logic        b_in_ready, b_conv_done, b_blank, b_ovf;
   logic [3:0]  b_digit;
   logic [1:0]  b_place;
   logic [1:0]  b_place_before = 2'd2;

   int checks = 0;
   int errors = 0;
   int sb_a[$];
   int sb_b[$];
   int shown_a = 0;
   int shown_b = 0;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      a_place_before <= a_place;
      b_place_before <= b_place;
   end

   bcd_scan_display #(.WIDTH(16), .DIGITS(DA), .DWELL_POW2(2)) u_dut_a (
      .clock(clock), .reset_n(reset_n), .in_valid(a_in_valid), .in_binary(a_in_binary),
      .in_ready(a_in_ready), .conv_done(a_conv_done), .digit(a_digit), .digit_place(a_place),
      .digit_blank(a_blank), .overflow(a_ovf)
   );

   bcd_scan_display #(.WIDTH(16), .DIGITS(DB), .DWELL_POW2(2)) u_dut_b (
      .clock(clock), .reset_n(reset_n), .in_valid(b_in_valid), .in_binary(b_in_binary),
      .in_ready(b_in_ready), .conv_done(b_conv_done), .digit(b_digit), .digit_place(b_place),
      .digit_blank(b_blank), .overflow(b_ovf)
   );

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic int exp_digit(input int v, input int d, input int p);
      return ((v % pow10(d)) / pow10(p)) % 10;
   endfunction

   function automatic int exp_ovf(input int v, input int d);
      return (v >= pow10(d)) ? 1 : 0;
   endfunction

   function automatic int exp_blank(input int v, input int d, input int p);
`ifdef LEADING_ZERO_BLANK_EN
      return ((p != 0) && ((v % pow10(d)) < pow10(p))) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic obs(input int sel, output int place, output int dig, output int ovf,
                      output int blk, output int rdy, output int done, output int fs);
      if (sel == 0) begin
         place = int'(a_place); dig = int'(a_digit); ovf = int'(a_ovf); blk = int'(a_blank);
         rdy = int'(a_in_ready); done = int'(a_conv_done);
         fs = (a_place_before == 3'd0 && a_place == 3'd4) ? 1 : 0;
      end else begin
         place = int'(b_place); dig = int'(b_digit); ovf = int'(b_ovf); blk = int'(b_blank);
         rdy = int'(b_in_ready); done = int'(b_conv_done);
         fs = (b_place_before == 2'd0 && b_place == 2'd2) ? 1 : 0;
      end
   endtask

   task automatic drive(input int sel, input logic v, input int val);
      if (sel == 0) begin a_in_valid = v; a_in_binary = 16'(val); end
      else          begin b_in_valid = v; b_in_binary = 16'(val); end
   endtask

   task automatic wait_frame_start(input int sel);
      int pl, dg, ov, bl, rd, dn, fs, k;
      k = 0;
      obs(sel, pl, dg, ov, bl, rd, dn, fs);
      while (fs == 0 && k < 100) begin
         @(negedge clock); k++;
         obs(sel, pl, dg, ov, bl, rd, dn, fs);
      end
      chk("frame_start_wait", fs, 1);
   endtask

   // Handshake one value; when hold is set, in_valid stays high with next_v during the busy window.
   task automatic accept(input int sel, input int v, input int hold, input int next_v);
      int pl, dg, ov, bl, rd, dn, fs, k, low, done_at;
      drive(sel, 1'b1, v);
      k = 0;
      obs(sel, pl, dg, ov, bl, rd, dn, fs);
      while (rd == 0 && k < 100) begin
         @(negedge clock); k++;
         obs(sel, pl, dg, ov, bl, rd, dn, fs);
      end
      chk("ready_before_accept", rd, 1);
      if (sel == 0) sb_a.push_back(v); else sb_b.push_back(v);
      @(posedge clock);
      @(negedge clock);
      if (hold != 0) drive(sel, 1'b1, next_v); else drive(sel, 1'b0, 0);
      low = 0; done_at = -1;
      for (int c = 0; c < 40; c++) begin
         obs(sel, pl, dg, ov, bl, rd, dn, fs);
         if (dn != 0 && done_at < 0) done_at = c;
         if (rd != 0) break;
         low++;
         @(negedge clock);
      end
      chk("ready_low_cycles", low, LAT);
      chk("conv_done_latency", done_at, LAT);
      if (hold != 0) begin
         if (sel == 0) sb_a.push_back(next_v); else sb_b.push_back(next_v);
      end
   endtask

   // Old value must persist until the frame start, then one full frame shows the scoreboard head.
   task automatic check_frame(input int sel);
      int pl, dg, ov, bl, rd, dn, fs, k, d, v, old;
      d   = (sel == 0) ? DA : DB;
      old = (sel == 0) ? shown_a : shown_b;
      if (sel == 0) v = (sb_a.size() > 0) ? sb_a.pop_front() : -1;
      else          v = (sb_b.size() > 0) ? sb_b.pop_front() : -1;
      chk("scoreboard_nonempty", (v >= 0) ? 1 : 0, 1);
      k = 0;
      obs(sel, pl, dg, ov, bl, rd, dn, fs);
      while (fs == 0 && k < 200) begin
         chk("old_digit_held", dg, exp_digit(old, d, pl));
         chk("old_ovf_held", ov, exp_ovf(old, d));
         @(negedge clock); k++;
         obs(sel, pl, dg, ov, bl, rd, dn, fs);
      end
      chk("frame_start_seen", fs, 1);
      for (int p = d - 1; p >= 0; p--) begin
         obs(sel, pl, dg, ov, bl, rd, dn, fs);
         chk("digit_place", pl, p);
         chk("digit_value", dg, exp_digit(v, d, p));
         chk("overflow", ov, exp_ovf(v, d));
         chk("digit_blank", bl, exp_blank(v, d, p));
         $display("inst %0d value %0d place %0d digit %0d ovf %0d blank %0d", sel, v, pl, dg, ov, bl);
         if (p > 0) repeat (4) @(negedge clock);
      end
      if (sel == 0) shown_a = v; else shown_b = v;
   endtask

   initial begin
      int pl, dg, ov, bl, rd, dn, fs, seen_done;

      // Reset state of both instances
      repeat (2) @(negedge clock);
      obs(0, pl, dg, ov, bl, rd, dn, fs);
      chk("rst_ready", rd, 1);
      chk("rst_done", dn, 0);
      chk("rst_digit", dg, 0);
      chk("rst_place", pl, DA - 1);
      chk("rst_blank", bl, 0);
      chk("rst_ovf", ov, 0);
      obs(1, pl, dg, ov, bl, rd, dn, fs);
      chk("rst_place_b", pl, DB - 1);
      reset_n = 1'b1;

      // Asynchronous reset in the middle of a conversion
      repeat (7) @(negedge clock);
      drive(0, 1'b1, 9999);
      @(posedge clock);
      @(negedge clock);
      drive(0, 1'b0, 0);
      repeat (5) @(negedge clock);
      obs(0, pl, dg, ov, bl, rd, dn, fs);
      chk("busy_mid_shift", rd, 0);
      #2 reset_n = 1'b0;
      #1;
      obs(0, pl, dg, ov, bl, rd, dn, fs);
      $display("async reset: ready %0d place %0d digit %0d done %0d", rd, pl, dg, dn);
      chk("async_rst_ready", rd, 1);
      chk("async_rst_place", pl, DA - 1);
      chk("async_rst_digit", dg, 0);
      chk("async_rst_done", dn, 0);
      @(negedge clock);
      reset_n = 1'b1;
      seen_done = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         obs(0, pl, dg, ov, bl, rd, dn, fs);
         if (dn != 0) seen_done = 1;
      end
      chk("aborted_no_done", seen_done, 0);

      // Full-scale value
      accept(0, 65535, 0, 0);
      check_frame(0);

      // Commit mid-frame: old digits hold until the wrap
      wait_frame_start(0);
      repeat (12) @(negedge clock);
      accept(0, 123, 0, 0);
      check_frame(0);

      // in_valid held through the busy window: 42 converts, 7 waits for in_ready
      wait_frame_start(0);
      accept(0, 42, 1, 7);
      @(negedge clock);
      obs(0, pl, dg, ov, bl, rd, dn, fs);
      chk("held_value_accepted", rd, 0);
      chk("done_single_pulse", dn, 0);
      drive(0, 1'b0, 0);
      check_frame(0);
      check_frame(0);

      // Truncation with three digits
      accept(1, 1234, 0, 0);
      check_frame(1);

      // Leading-zero cases
      accept(0, 7, 0, 0);
      check_frame(0);
      accept(0, 0, 0, 0);
      check_frame(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
